// File: rtl/clint_trap_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : clint_trap_ctrl
// Description : Core-local trap sequencer. Accepts ecall/mret from ID and
//               external/timer interrupts, then writes MEPC, MCAUSE and
//               MSTATUS into the CSR file one per cycle, holds the pipeline
//               for the whole sequence and issues a PC redirect at the end.
//               Optional machine timer enabled by defining CLINT_TIMER_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module clint_trap_ctrl #(
    parameter logic [31:0] TIMER_PERIOD = 32'd100000,
    parameter logic [31:0] CAUSE_ECALL  = 32'h0000000B
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ecall_id,
    input  logic        mret_id,
    input  logic [31:0] inst_pc_id,
    input  logic        irq_ext,
    input  logic        interrupt_enable,
    input  logic [31:0] clint_csr_mstatus,
    input  logic [31:0] clint_csr_mepc,
    input  logic [31:0] clint_csr_mtvec,
    input  logic        csr_we_ex,
    output logic        we_clint,
    output logic [11:0] wa_clint,
    output logic [31:0] wd_clint,
    output logic        stall_pipe,
    output logic        trap_jump,
    output logic [31:0] trap_target
);

    localparam logic [11:0] c_addr_mstatus = 12'h300;
    localparam logic [11:0] c_addr_mepc    = 12'h341;
    localparam logic [11:0] c_addr_mcause  = 12'h342;
    localparam logic [31:0] c_cause_ext    = 32'h8000000B;
    localparam logic [31:0] c_cause_timer  = 32'h80000007;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_W_MEPC    = 3'd1,
        S_W_MCAUSE  = 3'd2,
        S_W_MSTATUS = 3'd3,
        S_R_MSTATUS = 3'd4,
        S_JUMP      = 3'd5
    } state_t;

    state_t      r_state;
    state_t      w_next_state;

    logic [31:0] r_cause;
    logic [31:0] r_pc;
    logic [31:0] r_mstatus;
    logic [31:0] r_mepc;
    logic [29:0] r_mtvec;
    logic        r_is_mret;

    logic        w_timer_irq;
    logic        w_sel_mret;
    logic        w_sel_ecall;
    logic        w_sel_ext;
    logic        w_sel_timer;
    logic        w_accept;
    logic [31:0] w_cause;
    logic [31:0] w_mstatus_trap;
    logic [31:0] w_mstatus_mret;

    // mtvec is direct-mode only, so the mode bits are never consumed
    logic        w_unused_mtvec_mode;
    assign w_unused_mtvec_mode = ^clint_csr_mtvec[1:0];

    // Event priority: mret > ecall > enabled external irq > enabled timer irq
    assign w_sel_mret  = mret_id;
    assign w_sel_ecall = ~mret_id & ecall_id;
    assign w_sel_ext   = ~mret_id & ~ecall_id & irq_ext & interrupt_enable;
    assign w_sel_timer = ~mret_id & ~ecall_id & ~(irq_ext & interrupt_enable) & w_timer_irq;
    assign w_accept    = rst & (r_state == S_IDLE) &
                         (w_sel_mret | w_sel_ecall | w_sel_ext | w_sel_timer);
    assign w_cause     = w_sel_ecall ? CAUSE_ECALL :
                         w_sel_ext   ? c_cause_ext :
                         w_sel_timer ? c_cause_timer : 32'd0;

    // Trap entry: MPIE<=MIE, MIE<=0, MPP<=M. Return: MIE<=MPIE, MPIE<=1.
    always_comb begin
        w_mstatus_trap        = r_mstatus;
        w_mstatus_trap[7]     = r_mstatus[3];
        w_mstatus_trap[3]     = 1'b0;
        w_mstatus_trap[12:11] = 2'b11;
        w_mstatus_mret        = r_mstatus;
        w_mstatus_mret[3]     = r_mstatus[7];
        w_mstatus_mret[7]     = 1'b1;
    end

`ifdef CLINT_TIMER_EN
    logic [31:0] r_timer_cnt;
    logic        r_timer_pend;

    assign w_timer_irq = r_timer_pend & interrupt_enable;

    // Free-running period counter with a sticky pending flag
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_timer_cnt  <= 32'd0;
            r_timer_pend <= 1'b0;
        end else begin
            if (r_timer_cnt == TIMER_PERIOD - 32'd1) begin
                r_timer_cnt  <= 32'd0;
                r_timer_pend <= 1'b1;
            end else begin
                r_timer_cnt <= r_timer_cnt + 32'd1;
                if (w_accept && w_sel_timer) begin
                    r_timer_pend <= 1'b0;
                end
            end
        end
    end
`else
    logic w_unused_timer_period;
    assign w_unused_timer_period = ^TIMER_PERIOD;
    assign w_timer_irq           = 1'b0;
`endif

    // State register and event snapshot captured on the accept cycle
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_cause   <= 32'd0;
            r_pc      <= 32'd0;
            r_mstatus <= 32'd0;
            r_mepc    <= 32'd0;
            r_mtvec   <= 30'd0;
            r_is_mret <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_cause   <= w_cause;
                r_pc      <= inst_pc_id;
                r_mstatus <= clint_csr_mstatus;
                r_mepc    <= clint_csr_mepc;
                r_mtvec   <= clint_csr_mtvec[31:2];
                r_is_mret <= w_sel_mret;
            end
        end
    end

    // Next state and outputs; a W_/R_ state retries while EX owns the CSR port
    always_comb begin
        w_next_state = r_state;
        we_clint     = 1'b0;
        wa_clint     = 12'd0;
        wd_clint     = 32'd0;
        stall_pipe   = 1'b0;
        trap_jump    = 1'b0;
        trap_target  = 32'd0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    stall_pipe   = 1'b1;
                    w_next_state = w_sel_mret ? S_R_MSTATUS : S_W_MEPC;
                end
            end
            S_W_MEPC: begin
                stall_pipe = 1'b1;
                we_clint   = 1'b1;
                wa_clint   = c_addr_mepc;
                wd_clint   = r_pc;
                if (!csr_we_ex) w_next_state = S_W_MCAUSE;
            end
            S_W_MCAUSE: begin
                stall_pipe = 1'b1;
                we_clint   = 1'b1;
                wa_clint   = c_addr_mcause;
                wd_clint   = r_cause;
                if (!csr_we_ex) w_next_state = S_W_MSTATUS;
            end
            S_W_MSTATUS: begin
                stall_pipe = 1'b1;
                we_clint   = 1'b1;
                wa_clint   = c_addr_mstatus;
                wd_clint   = w_mstatus_trap;
                if (!csr_we_ex) w_next_state = S_JUMP;
            end
            S_R_MSTATUS: begin
                stall_pipe = 1'b1;
                we_clint   = 1'b1;
                wa_clint   = c_addr_mstatus;
                wd_clint   = w_mstatus_mret;
                if (!csr_we_ex) w_next_state = S_JUMP;
            end
            S_JUMP: begin
                stall_pipe   = 1'b1;
                trap_jump    = 1'b1;
                trap_target  = r_is_mret ? r_mepc : {r_mtvec, 2'b00};
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
        // Reset silences every output immediately so no further CSR write escapes
        if (!rst) begin
            w_next_state = S_IDLE;
            we_clint     = 1'b0;
            wa_clint     = 12'd0;
            wd_clint     = 32'd0;
            stall_pipe   = 1'b0;
            trap_jump    = 1'b0;
            trap_target  = 32'd0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_clint_trap_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_clint_trap_ctrl
// Description : Self-checking bench for clint_trap_ctrl. A transaction model
//               predicts the ordered CSR writes and the redirect target of
//               each accepted event; directed cases plus randomized events.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clint_trap_ctrl;

    localparam logic [11:0] A_MSTATUS   = 12'h300;
    localparam logic [11:0] A_MEPC      = 12'h341;
    localparam logic [11:0] A_MCAUSE    = 12'h342;
    localparam logic [31:0] CAUSE_ECALL = 32'h0000000B;
    localparam logic [31:0] CAUSE_EXT   = 32'h8000000B;

    typedef struct {
        logic [11:0] a;
        logic [31:0] d;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        ecall_id;
    logic        mret_id;
    logic [31:0] inst_pc_id;
    logic        irq_ext;
    logic        interrupt_enable;
    logic [31:0] clint_csr_mstatus;
    logic [31:0] clint_csr_mepc;
    logic [31:0] clint_csr_mtvec;
    logic        csr_we_ex;
    logic        we_clint;
    logic [11:0] wa_clint;
    logic [31:0] wd_clint;
    logic        stall_pipe;
    logic        trap_jump;
    logic [31:0] trap_target;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    clint_trap_ctrl #(
        .TIMER_PERIOD (32'd16),
        .CAUSE_ECALL  (CAUSE_ECALL)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .ecall_id          (ecall_id),
        .mret_id           (mret_id),
        .inst_pc_id        (inst_pc_id),
        .irq_ext           (irq_ext),
        .interrupt_enable  (interrupt_enable),
        .clint_csr_mstatus (clint_csr_mstatus),
        .clint_csr_mepc    (clint_csr_mepc),
        .clint_csr_mtvec   (clint_csr_mtvec),
        .csr_we_ex         (csr_we_ex),
        .we_clint          (we_clint),
        .wa_clint          (wa_clint),
        .wd_clint          (wd_clint),
        .stall_pipe        (stall_pipe),
        .trap_jump         (trap_jump),
        .trap_target       (trap_target)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Architectural mstatus update on trap entry
    function automatic logic [31:0] trap_ms(input logic [31:0] s);
        logic [31:0] r;
        r        = s;
        r[7]     = s[3];
        r[3]     = 1'b0;
        r[12:11] = 2'b11;
        return r;
    endfunction

    // Architectural mstatus update on mret
    function automatic logic [31:0] mret_ms(input logic [31:0] s);
        logic [31:0] r;
        r    = s;
        r[3] = s[7];
        r[7] = 1'b1;
        return r;
    endfunction

    // Idle cycles: no events, random EX CSR traffic; nothing may happen
    task automatic idle_cycles(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            ecall_id  = 1'b0;
            mret_id   = 1'b0;
            irq_ext   = 1'b0;
            csr_we_ex = 1'($urandom);
            #4;
            chk({tag, " idle we/stall/jump"}, 32'({we_clint, stall_pipe, trap_jump}), 32'd0);
        end
    endtask

    // Present one event set for a cycle and follow the whole sequence
    task automatic run_seq(input bit m, input bit e, input bit irq, input bit en,
                           input logic [31:0] pc, input logic [31:0] ms,
                           input logic [31:0] mepc, input logic [31:0] mtvec,
                           input logic [15:0] ex_pat, input int exp_lat, input string tag);
        int          kind;
        wr_t         q[$];
        logic [31:0] tgt;
        bit          done;
        kind = m ? 1 : e ? 2 : (irq && en) ? 3 : 0;
        @(posedge clk); #1;
        mret_id           = m;
        ecall_id          = e;
        irq_ext           = irq;
        interrupt_enable  = en;
        inst_pc_id        = pc;
        clint_csr_mstatus = ms;
        clint_csr_mepc    = mepc;
        clint_csr_mtvec   = mtvec;
        csr_we_ex         = ex_pat[0];
        #4;
        chk({tag, " accept stall"}, 32'(stall_pipe), 32'(kind != 0));
        chk({tag, " accept we"}, 32'(we_clint), 32'd0);
        if (kind == 0) begin
            mret_id  = 1'b0;
            ecall_id = 1'b0;
            irq_ext  = 1'b0;
            return;
        end
        if (kind == 1) begin
            q.push_back('{A_MSTATUS, mret_ms(ms)});
            tgt = mepc;
        end else begin
            q.push_back('{A_MEPC, pc});
            q.push_back('{A_MCAUSE, (kind == 2) ? CAUSE_ECALL : CAUSE_EXT});
            q.push_back('{A_MSTATUS, trap_ms(ms)});
            tgt = {mtvec[31:2], 2'b00};
        end
        done = 1'b0;
        for (int cyc = 1; cyc < 40 && !done; cyc++) begin
            @(posedge clk); #1;
            csr_we_ex         = (cyc < 16) ? ex_pat[cyc] : 1'b0;
            clint_csr_mstatus = $urandom;
            clint_csr_mepc    = $urandom;
            clint_csr_mtvec   = $urandom;
            inst_pc_id        = $urandom;
            #4;
            chk({tag, " seq stall"}, 32'(stall_pipe), 32'd1);
            if (q.size() > 0) begin
                chk({tag, " we"}, 32'(we_clint), 32'd1);
                chk({tag, " wa"}, 32'(wa_clint), 32'(q[0].a));
                chk({tag, " wd"}, wd_clint, q[0].d);
                chk({tag, " early jump"}, 32'(trap_jump), 32'd0);
                if (!csr_we_ex) void'(q.pop_front());
            end else begin
                chk({tag, " trap_jump"}, 32'(trap_jump), 32'd1);
                chk({tag, " target"}, trap_target, tgt);
                chk({tag, " jump we"}, 32'(we_clint), 32'd0);
                if (exp_lat > 0) chk({tag, " latency"}, 32'(cyc), 32'(exp_lat));
                done      = 1'b1;
                mret_id   = 1'b0;
                ecall_id  = 1'b0;
                irq_ext   = 1'b0;
                csr_we_ex = 1'b0;
            end
        end
        chk({tag, " completed in budget"}, 32'(done), 32'd1);
    endtask

    initial begin
        rst               = 1'b0;
        ecall_id          = 1'b0;
        mret_id           = 1'b0;
        inst_pc_id        = 32'd0;
        irq_ext           = 1'b0;
        interrupt_enable  = 1'b0;
        clint_csr_mstatus = 32'd0;
        clint_csr_mepc    = 32'd0;
        clint_csr_mtvec   = 32'd0;
        csr_we_ex         = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1; ecall_id = 1'b1; #4;
        chk("reset ctl", 32'({we_clint, stall_pipe, trap_jump}), 32'd0);
        chk("reset wa", 32'(wa_clint), 32'd0);
        chk("reset wd", wd_clint, 32'd0);
        chk("reset target", trap_target, 32'd0);
        @(posedge clk); #1;
        ecall_id = 1'b0;
        rst      = 1'b1;

`ifdef CLINT_TIMER_EN
        begin
            bit seen;
            interrupt_enable = 1'b1;
            seen = 1'b0;
            for (int i = 0; i < 40 && !seen; i++) begin
                @(posedge clk); #5;
                if (stall_pipe) seen = 1'b1;
            end
            chk("timer accept", 32'(seen), 32'd1);
            @(posedge clk); #5;
            chk("timer mepc wa", 32'(wa_clint), 32'(A_MEPC));
            @(posedge clk); #5;
            chk("timer mcause wa", 32'(wa_clint), 32'(A_MCAUSE));
            chk("timer mcause wd", wd_clint, 32'h80000007);
        end
`else
        // 1: ecall from M-mode
        run_seq(0, 1, 0, 0, 32'h100, 32'h8, 32'h0, 32'h201, 16'h0, 4, "ecall");
        idle_cycles(2, "post-ecall");

        // 2: masked external interrupt is ignored, then taken once enabled
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            irq_ext          = 1'b1;
            interrupt_enable = 1'b0;
            #4;
            chk("masked irq", 32'({we_clint, stall_pipe}), 32'd0);
        end
        run_seq(0, 0, 1, 1, 32'h2000, 32'h0000_0088, 32'h0, 32'h400, 16'h0, 4, "ext irq");
        idle_cycles(2, "post-irq");

        // 3: mret
        run_seq(1, 0, 0, 0, 32'h300, 32'h1880, 32'h104, 32'h0, 16'h0, 2, "mret");
        idle_cycles(1, "post-mret");

        // 4: EX stage owns the CSR port for two cycles during MCAUSE
        run_seq(0, 1, 0, 0, 32'h500, 32'h8, 32'h0, 32'h800, 16'h000C, 6, "contention");
        idle_cycles(1, "post-contention");

        // 5: reset while MCAUSE is being written
        @(posedge clk); #1;
        ecall_id          = 1'b1;
        inst_pc_id        = 32'h600;
        clint_csr_mstatus = 32'h8;
        #4;
        chk("rst-seq accept", 32'(stall_pipe), 32'd1);
        @(posedge clk); #5;
        chk("rst-seq mepc", 32'(wa_clint), 32'(A_MEPC));
        @(posedge clk); #1;
        rst = 1'b0;
        #4;
        chk("rst-seq in reset", 32'({we_clint, stall_pipe, trap_jump}), 32'd0);
        @(posedge clk); #1;
        rst      = 1'b1;
        ecall_id = 1'b0;
        #4;
        chk("rst-seq after", 32'({we_clint, stall_pipe, trap_jump}), 32'd0);
        idle_cycles(4, "rst-seq no write");

        // Priority: mret beats ecall and irq; ecall beats irq
        run_seq(1, 1, 1, 1, 32'h700, 32'h0000_1800, 32'h7700, 32'h0, 16'h0, 2, "prio mret");
        idle_cycles(1, "post-prio");
        run_seq(0, 1, 1, 1, 32'h704, 32'h0000_0008, 32'h0, 32'h9000, 16'h0, 4, "prio ecall");
        idle_cycles(1, "post-prio2");

        // Randomized events, contention patterns and mid-sequence CSR changes
        for (int n = 0; n < 40; n++) begin
            run_seq(($urandom % 4) == 0, ($urandom % 3) == 0, 1'($urandom), 1'($urandom),
                    $urandom & 32'hFFFF_FFFC, $urandom, $urandom, $urandom,
                    16'($urandom & $urandom) & 16'hFFFE, -1, "random");
            idle_cycles(1 + ($urandom % 3), "random gap");
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
